// File: rtl/optimizer_phase_sequencer_pkg.sv
// Shared types for the optimiser phase sequencer: FSM state encoding, phase codes,
// eta constant format and the phase-ordering helpers used by the sequencer FSM.
package optimizer_phase_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_M1_ISS  = 3'd1,
    ST_M1_WAIT = 3'd2,
    ST_M2_ISS  = 3'd3,
    ST_M2_WAIT = 3'd4,
    ST_AD_ISS  = 3'd5,
    ST_AD_WAIT = 3'd6,
    ST_FIN     = 3'd7
  } state_t;

  localparam logic [1:0] PHASE_IDLE = 2'd0;
  localparam logic [1:0] PHASE_MAN1 = 2'd1;
  localparam logic [1:0] PHASE_MAN2 = 2'd2;
  localparam logic [1:0] PHASE_ADAM = 2'd3;

  // Learning rate as consumed downstream: phase tag plus IEEE-754 single value.
  typedef struct packed {
    logic [1:0]  tag;
    logic [31:0] value;
  } eta_t;

  function automatic eta_t eta_for_phase(input logic [1:0] phase);
    eta_t e;
    e.tag = phase;
    case (phase)
      PHASE_MAN1: e.value = 32'h3DCC_CCCD;
      PHASE_MAN2: e.value = 32'h3C23_D70A;
      PHASE_ADAM: e.value = 32'h3A83_126F;
      default:    e.value = 32'h0000_0000;
    endcase
    return e;
  endfunction

  function automatic logic [1:0] state_phase(input state_t s);
    logic [1:0] p;
    case (s)
      ST_M1_ISS, ST_M1_WAIT: p = PHASE_MAN1;
      ST_M2_ISS, ST_M2_WAIT: p = PHASE_MAN2;
      ST_AD_ISS, ST_AD_WAIT: p = PHASE_ADAM;
      default:               p = PHASE_IDLE;
    endcase
    return p;
  endfunction

  function automatic state_t issue_state(input logic [1:0] phase);
    state_t s;
    case (phase)
      PHASE_MAN1: s = ST_M1_ISS;
      PHASE_MAN2: s = ST_M2_ISS;
      PHASE_ADAM: s = ST_AD_ISS;
      default:    s = ST_FIN;
    endcase
    return s;
  endfunction

  // First phase after from_phase whose count is non-zero; nonzero = {adam, man2, man1}.
  function automatic state_t next_entry(input logic [2:0] nonzero, input logic [1:0] from_phase);
    state_t s;
    s = ST_FIN;
    case (from_phase)
      PHASE_IDLE: begin
        if (nonzero[0])      s = ST_M1_ISS;
        else if (nonzero[1]) s = ST_M2_ISS;
        else if (nonzero[2]) s = ST_AD_ISS;
        else                 s = ST_FIN;
      end
      PHASE_MAN1: begin
        if (nonzero[1])      s = ST_M2_ISS;
        else if (nonzero[2]) s = ST_AD_ISS;
        else                 s = ST_FIN;
      end
      PHASE_MAN2: begin
        if (nonzero[2])      s = ST_AD_ISS;
        else                 s = ST_FIN;
      end
      default: s = ST_FIN;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/optimizer_phase_sequencer_if.sv
// Handshake and status bundle between the phase sequencer (master) and the
// training-loop update engine / run controller (slave).
interface optimizer_phase_sequencer_if #(
  parameter int CNT_WIDTH = 16,
  parameter int TOT_WIDTH = 18
);
  logic                 start;
  logic [CNT_WIDTH-1:0] cfg_n_man1;
  logic [CNT_WIDTH-1:0] cfg_n_man2;
  logic [CNT_WIDTH-1:0] cfg_n_adam;
  logic                 iter_done;
  logic                 converged;
  logic                 iter_start;
  logic                 manhattan_en;
  logic                 adam_en;
  logic                 finish_first_manhattan;
  logic                 finish_second_manhattan;
  logic [1:0]           phase;
  logic [CNT_WIDTH-1:0] iter_count;
  logic [TOT_WIDTH-1:0] total_iter;
  logic                 busy;
  logic                 done;
  logic                 done_converged;

  modport master (
    input  start, cfg_n_man1, cfg_n_man2, cfg_n_adam, iter_done, converged,
    output iter_start, manhattan_en, adam_en, finish_first_manhattan,
           finish_second_manhattan, phase, iter_count, total_iter, busy, done, done_converged
  );

  modport slave (
    output start, cfg_n_man1, cfg_n_man2, cfg_n_adam, iter_done, converged,
    input  iter_start, manhattan_en, adam_en, finish_first_manhattan,
           finish_second_manhattan, phase, iter_count, total_iter, busy, done, done_converged
  );
endinterface

// File: rtl/optimizer_phase_sequencer_phase_iter_counter.sv
// Per-phase completed-iteration counter with terminal-count compare against the
// limit of the phase currently running.
module phase_iter_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 inc,
  input  logic [CNT_WIDTH-1:0] limit,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 terminal
);

  logic [CNT_WIDTH-1:0] count_r;
  logic [CNT_WIDTH-1:0] count_inc_s;

  assign count_inc_s = count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  // Combinational so the FSM can leave the phase on the completing iter_done.
  assign terminal    = (count_inc_s == limit);
  assign count       = count_r;

  // Clear wins over increment so a new phase always starts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (inc) begin
      count_r <= count_inc_s;
    end
  end

endmodule

// File: rtl/optimizer_phase_sequencer.sv
// Run-level controller stepping the optimiser through Manhattan-1, Manhattan-2 and Adam
// phases; issues iterations, counts completions and ends on exhaustion or convergence.
module optimizer_phase_sequencer
  import optimizer_phase_sequencer_pkg::*;
#(
  parameter int CNT_WIDTH = 16,
  parameter int TOT_WIDTH = 18
) (
  input logic                        clk,
  input logic                        rst,
  optimizer_phase_sequencer_if.master bus
);

  state_t               state_r, state_s;
  logic [CNT_WIDTH-1:0] n_man1_r, n_man2_r, n_adam_r;
  logic [CNT_WIDTH-1:0] limit_s;
  logic [CNT_WIDTH-1:0] iter_count_s;
  logic [TOT_WIDTH-1:0] total_r;
  logic [2:0]           nz_cfg_s, nz_lat_s;
  logic [1:0]           phase_next_s;
  logic                 latch_s, cnt_clr_s, cnt_inc_s, conv_exit_s, terminal_s;
  logic                 iter_start_r, manhattan_en_r, adam_en_r, ff_man_r, fs_man_r;
  logic [1:0]           phase_r;
  logic                 busy_r, done_r, done_conv_r;

  assign nz_cfg_s = {bus.cfg_n_adam != '0, bus.cfg_n_man2 != '0, bus.cfg_n_man1 != '0};
  assign nz_lat_s = {n_adam_r != '0, n_man2_r != '0, n_man1_r != '0};
  assign phase_next_s = state_phase(state_s);

  phase_iter_counter #(.CNT_WIDTH(CNT_WIDTH)) u_iter_counter (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr_s),
    .inc      (cnt_inc_s),
    .limit    (limit_s),
    .count    (iter_count_s),
    .terminal (terminal_s)
  );

  // Next-state, counter control and cfg latch decode.
  always_comb begin
    state_s     = state_r;
    latch_s     = 1'b0;
    cnt_clr_s   = 1'b0;
    cnt_inc_s   = 1'b0;
    conv_exit_s = 1'b0;
    limit_s     = '0;
    case (state_phase(state_r))
      PHASE_MAN1: limit_s = n_man1_r;
      PHASE_MAN2: limit_s = n_man2_r;
      PHASE_ADAM: limit_s = n_adam_r;
      default:    limit_s = '0;
    endcase
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          latch_s   = 1'b1;
          cnt_clr_s = 1'b1;
          state_s   = next_entry(nz_cfg_s, PHASE_IDLE);
        end else begin
          state_s   = ST_IDLE;
        end
      end
      ST_M1_ISS: state_s = ST_M1_WAIT;
      ST_M2_ISS: state_s = ST_M2_WAIT;
      ST_AD_ISS: state_s = ST_AD_WAIT;
      ST_M1_WAIT, ST_M2_WAIT, ST_AD_WAIT: begin
        if (bus.iter_done) begin
          cnt_inc_s = 1'b1;
          if (bus.converged) begin
            conv_exit_s = 1'b1;
            state_s     = ST_FIN;
          end else if (terminal_s) begin
            state_s   = next_entry(nz_lat_s, state_phase(state_r));
            // Final counts stay visible when the run ends on exhaustion.
            cnt_clr_s = (state_s != ST_FIN);
          end else begin
            state_s   = issue_state(state_phase(state_r));
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_FIN:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State, latched counts, run total and all outputs, decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      n_man1_r       <= '0;
      n_man2_r       <= '0;
      n_adam_r       <= '0;
      total_r        <= '0;
      iter_start_r   <= 1'b0;
      manhattan_en_r <= 1'b0;
      adam_en_r      <= 1'b0;
      ff_man_r       <= 1'b0;
      fs_man_r       <= 1'b0;
      phase_r        <= PHASE_IDLE;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      done_conv_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      if (latch_s) begin
        n_man1_r <= bus.cfg_n_man1;
        n_man2_r <= bus.cfg_n_man2;
        n_adam_r <= bus.cfg_n_adam;
        total_r  <= '0;
      end else if (cnt_inc_s) begin
        total_r  <= total_r + {{(TOT_WIDTH-1){1'b0}}, 1'b1};
      end
      iter_start_r   <= (state_s == ST_M1_ISS) || (state_s == ST_M2_ISS) || (state_s == ST_AD_ISS);
      manhattan_en_r <= (phase_next_s == PHASE_MAN1) || (phase_next_s == PHASE_MAN2);
      adam_en_r      <= (phase_next_s == PHASE_ADAM);
      ff_man_r       <= (phase_next_s == PHASE_MAN2);
      fs_man_r       <= (phase_next_s == PHASE_ADAM);
      phase_r        <= phase_next_s;
      busy_r         <= (state_s != ST_IDLE);
      done_r         <= (state_s == ST_FIN);
      done_conv_r    <= (state_s == ST_FIN) && conv_exit_s;
    end
  end

  assign bus.iter_start              = iter_start_r;
  assign bus.manhattan_en            = manhattan_en_r;
  assign bus.adam_en                 = adam_en_r;
  assign bus.finish_first_manhattan  = ff_man_r;
  assign bus.finish_second_manhattan = fs_man_r;
  assign bus.phase                   = phase_r;
  assign bus.iter_count              = iter_count_s;
  assign bus.total_iter              = total_r;
  assign bus.busy                    = busy_r;
  assign bus.done                    = done_r;
  assign bus.done_converged          = done_conv_r;

endmodule

// File: tb/tb_optimizer_phase_sequencer.sv
// Self-checking bench for optimizer_phase_sequencer: a run-level behavioural model checked
// every cycle, plus directed runs with hand-computed expectations.
module tb_optimizer_phase_sequencer;

  localparam int CW = 16;
  localparam int TW = 18;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  optimizer_phase_sequencer_if #(.CNT_WIDTH(CW), .TOT_WIDTH(TW)) bus ();

  optimizer_phase_sequencer #(.CNT_WIDTH(CW), .TOT_WIDTH(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Run-level model: phase number, whether the issued iteration is outstanding, counts.
  int unsigned lim[4];
  int          m_phase = 0;
  bit          m_wait = 0, m_fin = 0, m_done = 0, m_dconv = 0, model_valid = 0;
  int unsigned m_cnt = 0, m_tot = 0;

  function automatic int m_next(input int from);
    for (int p = from + 1; p <= 3; p++) if (lim[p] != 0) return p;
    return 0;
  endfunction

  task automatic m_finish(input bit conv);
    m_phase = 0; m_wait = 0; m_fin = 1; m_done = 1; m_dconv = conv;
  endtask

  task automatic m_enter(input int p);
    if (p == 0) m_finish(1'b0);
    else begin m_phase = p; m_cnt = 0; m_wait = 0; end
  endtask

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_phase = 0; m_wait = 0; m_fin = 0; m_done = 0; m_dconv = 0; m_cnt = 0; m_tot = 0;
      for (int i = 0; i < 4; i++) lim[i] = 0;
    end else begin
      m_done = 0; m_dconv = 0;
      if (m_fin) m_fin = 0;
      else if (m_phase == 0) begin
        if (bus.start) begin
          lim[1] = bus.cfg_n_man1; lim[2] = bus.cfg_n_man2; lim[3] = bus.cfg_n_adam;
          m_tot = 0; m_cnt = 0;
          m_enter(m_next(0));
        end
      end else if (!m_wait) m_wait = 1;
      else if (bus.iter_done) begin
        m_cnt++; m_tot++;
        if (bus.converged) m_finish(1'b1);
        else if (m_cnt == lim[m_phase]) m_enter(m_next(m_phase));
        else m_wait = 0;
      end
    end
    model_valid = 1;
  end

  // Logs of observed iteration launches and run completions.
  int ph_log[$];
  bit ff_log[$], fs_log[$];
  int done_seen = 0;
  int last_total = 0;
  bit last_dconv = 0;

  initial forever begin
    @(negedge clk);
    if (model_valid) begin
      check("iter_start",   bus.iter_start,              (m_phase != 0) && !m_wait);
      check("phase",        bus.phase,                   m_phase);
      check("manhattan_en", bus.manhattan_en,            (m_phase == 1) || (m_phase == 2));
      check("adam_en",      bus.adam_en,                 m_phase == 3);
      check("finish_first", bus.finish_first_manhattan,  m_phase == 2);
      check("finish_second",bus.finish_second_manhattan, m_phase == 3);
      check("busy",         bus.busy,                    (m_phase != 0) || m_fin);
      check("done",         bus.done,                    m_done);
      check("done_conv",    bus.done_converged,          m_dconv);
      check("iter_count",   bus.iter_count,              m_cnt);
      check("total_iter",   bus.total_iter,              m_tot);
    end
    if (bus.iter_start === 1'b1) begin
      ph_log.push_back(int'(bus.phase));
      ff_log.push_back(bus.finish_first_manhattan);
      fs_log.push_back(bus.finish_second_manhattan);
    end
    if (bus.done === 1'b1) begin
      done_seen++;
      last_total = int'(bus.total_iter);
      last_dconv = bus.done_converged;
    end
  end

  int eng_cyc;
  bit eng_finished;

  task automatic tick();
    @(negedge clk);
    eng_cyc++;
    if (bus.done === 1'b1) eng_finished = 1'b1;
  endtask

  task automatic pulse_start(input int n1, input int n2, input int n3);
    ph_log.delete(); ff_log.delete(); fs_log.delete();
    bus.cfg_n_man1 = CW'(n1); bus.cfg_n_man2 = CW'(n2); bus.cfg_n_adam = CW'(n3);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Update-engine stand-in: answers each iter_start with iter_done 'gap' cycles later.
  task automatic engine(input int gap, input int conv_idx, input bit spur, input bit dbl, input int stop);
    int  n_done;
    bit  late;
    n_done = 0; late = 1'b0; eng_cyc = 0; eng_finished = 1'b0;
    while (!eng_finished && eng_cyc < 400 && (stop == 0 || n_done < stop)) begin
      if (bus.iter_start === 1'b1 || late) begin
        if (!late) begin
          if (spur) bus.iter_done = 1'b1;
          tick();
          bus.iter_done = 1'b0;
        end
        late = 1'b0;
        repeat (gap - 1) tick();
        n_done++;
        bus.iter_done = 1'b1;
        bus.converged = (n_done == conv_idx);
        tick();
        bus.converged = 1'b0;
        if (dbl && !eng_finished) begin
          late = (bus.iter_start === 1'b1);
          tick();
        end
        bus.iter_done = 1'b0;
      end else begin
        tick();
      end
    end
    if (stop == 0) check("engine_run_ended", eng_finished, 1'b1);
  endtask

  int exp_ph1[7] = '{1, 1, 2, 2, 3, 3, 3};
  bit exp_ff1[7] = '{0, 0, 1, 1, 0, 0, 0};
  bit exp_fs1[7] = '{0, 0, 0, 0, 1, 1, 1};
  int done_before;

  initial begin
    bus.start = 1'b0; bus.iter_done = 1'b0; bus.converged = 1'b0;
    bus.cfg_n_man1 = '0; bus.cfg_n_man2 = '0; bus.cfg_n_adam = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", bus.busy, 0);
    check("reset_phase", bus.phase, 0);
    check("reset_total", bus.total_iter, 0);
    rst = 1'b0;
    @(negedge clk);

    // Full run (2,2,3)
    pulse_start(2, 2, 3);
    engine(3, 0, 1'b0, 1'b0, 0);
    @(negedge clk);
    check("t1_launches", ph_log.size(), 7);
    for (int i = 0; i < 7 && i < ph_log.size(); i++) begin
      check("t1_phase_seq", ph_log[i], exp_ph1[i]);
      check("t1_ff_seq", ff_log[i], exp_ff1[i]);
      check("t1_fs_seq", fs_log[i], exp_fs1[i]);
    end
    check("t1_total", last_total, 7);
    check("t1_dconv", last_dconv, 0);
    check("t1_final_count", bus.iter_count, 3);

    // Convergence on the 2nd MAN2 completion
    pulse_start(5, 5, 5);
    engine(2, 7, 1'b0, 1'b0, 0);
    @(negedge clk);
    check("t2_total", last_total, 7);
    check("t2_dconv", last_dconv, 1);
    check("t2_launches", ph_log.size(), 7);

    // MAN1 skipped
    pulse_start(0, 3, 0);
    engine(2, 0, 1'b0, 1'b0, 0);
    @(negedge clk);
    check("t3_first_phase", ph_log.size() > 0 ? ph_log[0] : -1, 2);
    check("t3_first_ff", ff_log.size() > 0 ? int'(ff_log[0]) : -1, 1);
    check("t3_total", last_total, 3);

    // All zero: immediate done, then spurious iter_done in IDLE
    done_before = done_seen;
    pulse_start(0, 0, 0);
    check("t4_done_now", bus.done, 1);
    check("t4_total", bus.total_iter, 0);
    @(negedge clk);
    check("t4_done_gone", bus.done, 0);
    check("t4_busy_gone", bus.busy, 0);
    bus.iter_done = 1'b1; bus.converged = 1'b1;
    repeat (2) @(negedge clk);
    bus.iter_done = 1'b0; bus.converged = 1'b0;
    @(negedge clk);
    check("t4_idle_total", bus.total_iter, 0);
    check("t4_idle_busy", bus.busy, 0);
    check("t4_one_done", done_seen - done_before, 1);

    // Spurious iter_done in ISS and double pulses in WAIT
    pulse_start(2, 1, 1);
    engine(3, 0, 1'b1, 1'b1, 0);
    @(negedge clk);
    check("t5_total", last_total, 4);
    check("t5_launches", ph_log.size(), 4);

    // start and cfg changes while busy are ignored
    pulse_start(3, 0, 0);
    bus.start = 1'b1;
    bus.cfg_n_man1 = 16'd9; bus.cfg_n_man2 = 16'd9; bus.cfg_n_adam = 16'd9;
    engine(2, 0, 1'b0, 1'b0, 0);
    bus.start = 1'b0;
    @(negedge clk);
    check("t6_total", last_total, 3);
    check("t6_launches", ph_log.size(), 3);
    check("t6_idle_after", bus.busy, 0);

    // rst in AD_WAIT
    pulse_start(1, 1, 2);
    engine(3, 0, 1'b0, 1'b0, 3);
    done_before = done_seen;
    @(negedge clk);
    check("t7_in_adam", bus.adam_en, 1);
    rst = 1'b1;
    @(negedge clk);
    check("t7_rst_busy", bus.busy, 0);
    check("t7_rst_phase", bus.phase, 0);
    check("t7_rst_adam", bus.adam_en, 0);
    check("t7_rst_total", bus.total_iter, 0);
    check("t7_rst_count", bus.iter_count, 0);
    check("t7_no_done", done_seen - done_before, 0);
    rst = 1'b0;
    @(negedge clk);
    pulse_start(2, 2, 3);
    engine(3, 0, 1'b0, 1'b0, 0);
    @(negedge clk);
    check("t7_fresh_total", last_total, 7);
    check("t7_fresh_launches", ph_log.size(), 7);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
